// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of one synchronous RAM port among N_REQ requesters; RAM_ARB_LOCK_EN adds grant locking.
// Latency: grant and RAM strobes are combinational in the request cycle; rvalid/rdata return one cycle later.
// Backpressure: a requester holds req/we/addr/wdata until it sees gnt; a lock holds off the others for at most LOCK_MAX cycles.
module ram_port_arbiter #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic [N_REQ-1:0]            lock,
    output logic                        lock_err,
`endif
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [ADDR_WIDTH-1:0]       ram_a,
    output logic [DATA_WIDTH-1:0]       ram_d,
    output logic                        ram_w,
    input  logic [DATA_WIDTH-1:0]       ram_q
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 1 || N_REQ > 8 || LOCK_MAX < 1) begin : g_cfg_check
        $error("ram_port_arbiter: unsupported N_REQ or LOCK_MAX");
    end

    logic [PW-1:0]    rr_ptr;
    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             arb_any;
    logic [PW-1:0]    arb_next;
    logic [PW-1:0]    gnt_idx;
    logic             any_gnt;

    // Scan rr_ptr, rr_ptr+1, ... and take the first requester found.
    always_comb begin
        int idx;
        arb_gnt = '0;
        arb_idx = '0;
        arb_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!arb_any && req[idx]) begin
                arb_any      = 1'b1;
                arb_gnt[idx] = 1'b1;
                arb_idx      = PW'(idx);
            end
        end
    end

    assign arb_next = PW'((int'(arb_idx) + 1) % N_REQ);

`ifdef RAM_ARB_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_t;
    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t           state;
    logic [PW-1:0]    owner;
    logic [CW-1:0]    lock_cnt;
    logic [N_REQ-1:0] lock_ign;
    logic [N_REQ-1:0] lock_eff;
    logic             hold;

    // After a forced release the owner's lock bit is ignored until it is dropped.
    assign lock_eff = lock & ~lock_ign;
    assign hold     = (state == LOCKED) && lock_eff[owner];

    always_comb begin
        gnt     = arb_gnt;
        gnt_idx = arb_idx;
        any_gnt = arb_any;
        if (hold) begin
            gnt        = '0;
            gnt[owner] = req[owner];
            gnt_idx    = owner;
            any_gnt    = req[owner];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            state    <= ARB;
            owner    <= '0;
            lock_cnt <= '0;
            lock_err <= 1'b0;
            lock_ign <= '0;
        end else begin
            lock_err <= 1'b0;
            lock_ign <= lock_ign & lock;
            if (hold) begin
                if (int'(lock_cnt) + 1 >= LOCK_MAX) begin
                    state           <= ARB;
                    lock_cnt        <= '0;
                    lock_err        <= 1'b1;
                    lock_ign[owner] <= 1'b1;
                end else begin
                    lock_cnt <= lock_cnt + CW'(1);
                end
            end else begin
                // Unlocked cycle, including the one where the owner drops its lock.
                state    <= ARB;
                lock_cnt <= '0;
                if (arb_any) begin
                    rr_ptr <= arb_next;
                    if (lock_eff[arb_idx]) begin
                        state    <= LOCKED;
                        owner    <= arb_idx;
                        lock_cnt <= CW'(1);
                    end
                end
            end
        end
    end
`else
    assign gnt     = arb_gnt;
    assign gnt_idx = arb_idx;
    assign any_gnt = arb_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (arb_any) begin
            rr_ptr <= arb_next;
        end
    end
`endif

    always_comb begin
        ram_w = 1'b0;
        ram_a = '0;
        ram_d = '0;
        if (any_gnt) begin
            ram_w = we[gnt_idx];
            ram_a = addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_d = wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // RAM output register provides the data; only the return strobe is ours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= '0;
        end else begin
            rvalid <= gnt & ~we;
        end
    end

    assign rdata = ram_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vectors, read returns checked by a scoreboard monitor.
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    logic [1:0]  lock = '0;
    logic        lock_err;
`endif
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [15:0] rdata;
    logic [15:0] ram_a;
    logic [15:0] ram_d;
    logic        ram_w;
    logic [15:0] ram_q;
    logic [15:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  rv;
        logic [15:0] d;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .N_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .LOCK_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef RAM_ARB_LOCK_EN
        .lock(lock), .lock_err(lock_err),
`endif
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_a(ram_a), .ram_d(ram_d), .ram_w(ram_w), .ram_q(ram_q)
    );

    // Synchronous RAM, registered q, write-first.
    always @(posedge clk) begin
        if (ram_w) mem[ram_a[7:0]] <= ram_d;
        ram_q <= ram_w ? ram_d : mem[ram_a[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && rvalid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rvalid", {30'd0, rvalid}, {30'd0, e.rv});
                chk("rdata", {16'd0, rdata}, {16'd0, e.d});
            end
        end
    end

    // Called at posedge+1; drives one cycle and checks the combinational port outputs.
    task automatic step(input logic [1:0] r, input logic [1:0] w,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [1:0] eg, input string nm);
        logic [15:0] ea;
        logic        ew;
        req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
        ea = eg[1] ? a1 : (eg[0] ? a0 : 16'd0);
        ew = (eg & w) != 2'b00;
        #2;
        chk({nm, "_gnt"}, {30'd0, gnt}, {30'd0, eg});
        chk({nm, "_ram_w"}, {31'd0, ram_w}, {31'd0, ew});
        chk({nm, "_ram_a"}, {16'd0, ram_a}, {16'd0, ea});
        @(posedge clk); #1;
    endtask

    task automatic idle(input string nm);
        step(2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 2'b00, nm);
    endtask

    task automatic apply_reset();
        rst = 1'b0; req = '0; we = '0;
`ifdef RAM_ARB_LOCK_EN
        lock = '0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            chk("reset_rvalid", {30'd0, rvalid}, 32'd0);
            idle("reset_idle");
        end

        // Write 0xBEEF to 0x0010, then read it back.
        step(2'b01, 2'b01, 16'h0010, 16'h0, 16'hBEEF, 16'h0, 2'b01, "wr");
        exp_q.push_back('{rv: 2'b01, d: 16'hBEEF});
        step(2'b01, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0, 2'b01, "rd");
        idle("rd_ret");

        // Preload addresses 1 and 2 for the contention run.
        step(2'b10, 2'b10, 16'h0, 16'h0002, 16'h0, 16'hB002, 2'b10, "pre1");
        step(2'b01, 2'b01, 16'h0001, 16'h0, 16'hA001, 16'h0, 2'b01, "pre0");

        apply_reset();
        for (int k = 0; k < 6; k++) begin
            logic [1:0] eg;
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_q.push_back('{rv: eg, d: (k % 2 == 0) ? 16'hA001 : 16'hB002});
            step(2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0, 16'h0, eg, "contend");
        end
        idle("contend_ret");

        // Read-after-write on consecutive cycles.
        apply_reset();
        step(2'b10, 2'b10, 16'h0, 16'h0005, 16'h0, 16'h1234, 2'b10, "raw_wr");
        exp_q.push_back('{rv: 2'b01, d: 16'h1234});
        step(2'b01, 2'b00, 16'h0005, 16'h0, 16'h0, 16'h0, 2'b01, "raw_rd");
        idle("raw_ret");

        // Reset in the cycle after a read grant discards the return and rewinds rr_ptr.
        apply_reset();
        step(2'b01, 2'b00, 16'h0001, 16'h0, 16'h0, 16'h0, 2'b01, "mid_rd");
        rst = 1'b0; req = '0;
        #2;
        chk("midrst_rvalid", {30'd0, rvalid}, 32'd0);
        chk("midrst_gnt", {30'd0, gnt}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_rvalid2", {30'd0, rvalid}, 32'd0);
        rst = 1'b1;
        exp_q.push_back('{rv: 2'b01, d: 16'hA001});
        step(2'b11, 2'b00, 16'h0001, 16'h0002, 16'h0, 16'h0, 2'b01, "after_rst");
        idle("after_rst_ret");

`ifdef RAM_ARB_LOCK_EN
        // Forced release after LOCK_MAX=4 grants.
        apply_reset();
        lock = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 2'b11, 16'h0020, 16'h0021, 16'h0, 16'h0, 2'b01, "lock_hold");
            chk("lock_err_hold", {31'd0, lock_err}, (k == 3) ? 32'd1 : 32'd0);
        end
        step(2'b11, 2'b11, 16'h0020, 16'h0021, 16'h0, 16'h0, 2'b10, "lock_forced");
        chk("lock_err_after", {31'd0, lock_err}, 32'd0);
        step(2'b11, 2'b11, 16'h0020, 16'h0021, 16'h0, 16'h0, 2'b01, "lock_ignored");
        step(2'b11, 2'b11, 16'h0020, 16'h0021, 16'h0, 16'h0, 2'b10, "lock_not_relocked");

        // Lock dropped after two grants.
        apply_reset();
        lock = 2'b01;
        for (int k = 0; k < 2; k++) begin
            step(2'b11, 2'b11, 16'h0020, 16'h0021, 16'h0, 16'h0, 2'b01, "lock_short");
            chk("lock_err_short", {31'd0, lock_err}, 32'd0);
        end
        lock = 2'b00;
        step(2'b11, 2'b11, 16'h0020, 16'h0021, 16'h0, 16'h0, 2'b10, "lock_drop");
        chk("lock_err_drop", {31'd0, lock_err}, 32'd0);
`endif

        repeat (3) idle("drain");
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
